updown_btn_driver: RTL and testbench

Converts the two raw Basys3 push-buttons into the single-cycle `u`/`d` step pulses consumed by the up/down counter FSM. Each button is synchronized and debounced. A debounced press emits one pulse, and a held button auto-repeats. Sits between the board button pins and the counter's `u`/`d` inputs, so it is the producer end of that step interface.

---
 rtl/updown_btn_driver.sv | 127 ++++++++++++
 tb/tb_updown_btn_driver.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/updown_btn_driver.sv
// Push-button front end for the up/down counter: synchronizes and debounces two raw
// buttons and turns presses into single-cycle u/d step pulses with optional auto-repeat.
module updown_btn_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8,
  parameter bit REPEAT_EN       = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_up,
  input  logic btn_down,
  output logic u,
  output logic d,
  output logic locked
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

  logic [1:0]            up_sync, dn_sync;
  logic [1:0]            sync_lvl;   // [0] = up, [1] = down
  logic [1:0]            deb;        // debounced levels, same bit order
  logic [1:0][DB_W-1:0]  db_cnt;

  state_t                state;
  logic                  dir_dn;
  logic [TMR_W-1:0]      timer;
  logic                  btn_u, btn_d, active, other;
  logic [TMR_W-1:0]      timer_last;

  assign sync_lvl = {dn_sync[1], up_sync[1]};
  assign btn_u    = deb[0];
  assign btn_d    = deb[1];
  assign active   = dir_dn ? btn_d : btn_u;
  assign other    = dir_dn ? btn_u : btn_d;
  assign timer_last = (state == DELAY) ? DELAY_LAST : PERIOD_LAST;

  // Two-flop synchronizers feed a per-button run-length debouncer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      up_sync <= '0;
      dn_sync <= '0;
      deb     <= '0;
      db_cnt  <= '0;
    end else begin
      up_sync <= {up_sync[0], btn_up};
      dn_sync <= {dn_sync[0], btn_down};
      for (int i = 0; i < 2; i++) begin
        if (sync_lvl[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync_lvl[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      dir_dn <= 1'b0;
      timer  <= '0;
      u      <= 1'b0;
      d      <= 1'b0;
      locked <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here are overridden by later assignments in the
      // same block, which keeps every pulse exactly one cycle wide.
      u <= 1'b0;
      d <= 1'b0;
      unique case (state)
        IDLE: begin
          if (btn_u && btn_d) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (btn_u || btn_d) begin
            state  <= DELAY;
            dir_dn <= btn_d;
            timer  <= '0;
            u      <= btn_u;
            d      <= btn_d;
          end
        end
        DELAY, REPEAT: begin
          // Release and lock are checked first so they suppress a pulse due this edge.
          if (!active) begin
            state <= IDLE;
          end else if (other) begin
            state  <= LOCK;
            locked <= 1'b1;
          end else if (REPEAT_EN) begin
            if (timer == timer_last) begin
              state <= REPEAT;
              timer <= '0;
              u     <= !dir_dn;
              d     <= dir_dn;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        LOCK: begin
          if (!btn_u && !btn_d) begin
            state  <= IDLE;
            locked <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          locked <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_updown_btn_driver.sv
// Directed bench for updown_btn_driver: expected pulse edges go into a scoreboard
// when a button is driven and are matched by a negedge monitor as pulses appear.
module tb_updown_btn_driver;

  logic clk      = 1'b0;
  logic reset    = 1'b1;
  logic btn_up   = 1'b0;
  logic btn_down = 1'b0;
  logic u, d, locked;

  int cyc   = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int n_up  = 0;
  int n_dn  = 0;

  typedef struct {
    int   at;
    logic dn;
  } pulse_t;

  pulse_t sb[$];

  updown_btn_driver dut (
    .clk      (clk),
    .reset    (reset),
    .btn_up   (btn_up),
    .btn_down (btn_down),
    .u        (u),
    .d        (d),
    .locked   (locked)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_pulse(input int at, input logic dn);
    pulse_t p;
    p.at = at;
    p.dn = dn;
    sb.push_back(p);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin : monitor
    pulse_t p;
    if (u || d) begin
      check("u_d_exclusive", 32'(u & d), 32'd0);
      if (u) n_up++;
      if (d) n_dn++;
      if (sb.size() == 0) begin
        check("unexpected_pulse_edge", cyc, 32'hFFFF_FFFF);
      end else begin
        p = sb.pop_front();
        check("pulse_edge", cyc, p.at);
        check("pulse_dir_is_down", 32'(d), 32'(p.dn));
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, c0, up0, dn0;

    // Reset held, then 100 idle cycles
    @(negedge clk);
    check("rst_outputs_a", 32'({u, d, locked}), 32'd0);
    @(negedge clk);
    check("rst_outputs_b", 32'({u, d, locked}), 32'd0);
    #7 reset = 1'b0;
    repeat (100) begin
      @(negedge clk);
      check("idle_outputs", 32'({u, d, locked}), 32'd0);
    end

    // Single tap of up: one pulse at N+6
    up0 = n_up; dn0 = n_dn;
    @(negedge clk); n = cyc + 1; btn_up = 1'b1;
    expect_pulse(n + 6, 1'b0);
    wait_until(n + 9); btn_up = 1'b0;
    wait_until(n + 30);
    check("tap_up_count", n_up - up0, 32'd1);
    check("tap_dn_count", n_dn - dn0, 32'd0);
    check("tap_sb_empty", 32'(sb.size()), 32'd0);

    // Three-cycle glitch on down: rejected
    dn0 = n_dn;
    @(negedge clk); n = cyc + 1; btn_down = 1'b1;
    wait_until(n + 2); btn_down = 1'b0;
    wait_until(n + 15);
    check("glitch_dn_count", n_dn - dn0, 32'd0);
    check("glitch_locked", 32'(locked), 32'd0);

    // Auto-repeat: 60-cycle hold gives 7 pulses
    up0 = n_up;
    @(negedge clk); n = cyc + 1; btn_up = 1'b1;
    expect_pulse(n + 6, 1'b0);
    for (int k = 22; k <= 62; k += 8) expect_pulse(n + k, 1'b0);
    wait_until(n + 59); btn_up = 1'b0;
    wait_until(n + 90);
    check("repeat_up_count", n_up - up0, 32'd7);
    check("repeat_sb_empty", 32'(sb.size()), 32'd0);

    // Both buttons together: lock, no pulses
    up0 = n_up; dn0 = n_dn;
    @(negedge clk); n = cyc + 1; btn_up = 1'b1; btn_down = 1'b1;
    wait_until(n + 5);  check("lock_before", 32'(locked), 32'd0);
    wait_until(n + 6);  check("lock_set", 32'(locked), 32'd1);
    wait_until(n + 19); btn_up = 1'b0; btn_down = 1'b0;
    wait_until(n + 25); check("lock_held", 32'(locked), 32'd1);
    wait_until(n + 26); check("lock_cleared", 32'(locked), 32'd0);
    check("lock_up_count", n_up - up0, 32'd0);
    check("lock_dn_count", n_dn - dn0, 32'd0);

    // Down tap after lock: one d pulse
    dn0 = n_dn;
    @(negedge clk); n = cyc + 1; btn_down = 1'b1;
    expect_pulse(n + 6, 1'b1);
    wait_until(n + 9); btn_down = 1'b0;
    wait_until(n + 30);
    check("tap_dn_after_lock", n_dn - dn0, 32'd1);
    check("tap_dn_sb_empty", 32'(sb.size()), 32'd0);

    // Lock during an up hold: repeats stop, no d pulse
    up0 = n_up; dn0 = n_dn;
    @(negedge clk); n = cyc + 1; btn_up = 1'b1;
    expect_pulse(n + 6, 1'b0);
    expect_pulse(n + 22, 1'b0);
    expect_pulse(n + 30, 1'b0);
    wait_until(n + 29); btn_down = 1'b1;
    wait_until(n + 36); check("midhold_locked", 32'(locked), 32'd1);
    wait_until(n + 49); btn_up = 1'b0; btn_down = 1'b0;
    wait_until(n + 80);
    check("midhold_unlocked", 32'(locked), 32'd0);
    check("midhold_up_count", n_up - up0, 32'd3);
    check("midhold_dn_count", n_dn - dn0, 32'd0);
    check("midhold_sb_empty", 32'(sb.size()), 32'd0);

    // Reset while a repeat pulse is high
    up0 = n_up;
    @(negedge clk); n = cyc + 1; btn_up = 1'b1;
    expect_pulse(n + 6, 1'b0);
    expect_pulse(n + 22, 1'b0);
    wait_until(n + 22);
    check("pre_reset_u", 32'(u), 32'd1);
    c0 = cyc;
    #2 reset = 1'b1;
    #1;
    check("reset_drops_u", 32'(u), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    expect_pulse(c0 + 8, 1'b0);
    #9 reset = 1'b0;
    wait_until(c0 + 10); btn_up = 1'b0;
    wait_until(c0 + 40);
    check("post_reset_up_count", n_up - up0, 32'd3);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
